// File: rtl/vga_box_renderer.sv
// Pixel stage behind the VGA timing controller: draws a bouncing square on a flat
// background, with the syncs delayed to match the two-stage RGB pipeline.
module vga_box_renderer #(
    parameter int          H_ACTIVE  = 640,
    parameter int          V_ACTIVE  = 480,
    parameter int          BOX_SIZE  = 32,
    parameter int          STEP      = 2,
    parameter int          INIT_X    = 100,
    parameter int          INIT_Y    = 60,
    parameter logic [11:0] BOX_COLOR = 12'hF00,
    parameter logic [11:0] BG_COLOR  = 12'h00F
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        pause,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic [11:0] rgb,
    output logic        frame_tick
);

    typedef enum logic [1:0] {S_WAIT, S_MOVE_X, S_MOVE_Y} state_t;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir;   // 1 = moving towards larger coordinates
    } axis_t;

    // One bounce step along an axis whose visible extent is [0, limit).
    function automatic axis_t move_axis(input logic [9:0] pos, input logic dir,
                                        input logic [10:0] limit);
        axis_t      r;
        logic [10:0] ahead;
        // NOTE: every field gets a default first so no path leaves r unassigned;
        // the same rule keeps the always_comb below free of latches.
        r.pos = pos;
        r.dir = dir;
        ahead = {1'b0, pos} + 11'(STEP + BOX_SIZE);
        if (dir) begin
            if (ahead > limit) begin
                r.pos = 10'(limit - 11'(BOX_SIZE));
                r.dir = 1'b0;
            end else begin
                r.pos = pos + 10'(STEP);
            end
        end else if (pos < 10'(STEP)) begin
            r.pos = '0;
            r.dir = 1'b1;
        end else begin
            r.pos = pos - 10'(STEP);
        end
        return r;
    endfunction

    state_t     state_q, state_d;
    logic [9:0] box_x, box_y;
    logic       dir_x, dir_y;
    logic       ld_x, ld_y;
    logic       video_on_d, hsync_d, vsync_d, hit_d;
    logic       vsync_hist;
    logic       hit, frame_det;
    axis_t      next_x, next_y;

    // Compare at 11 bits so box_x + BOX_SIZE cannot wrap near the right edge.
    assign hit = ({1'b0, x} >= {1'b0, box_x}) && ({1'b0, x} < {1'b0, box_x} + 11'(BOX_SIZE)) &&
                 ({1'b0, y} >= {1'b0, box_y}) && ({1'b0, y} < {1'b0, box_y} + 11'(BOX_SIZE));

    assign frame_det = p_tick && vsync_hist && !vsync_in;
    assign next_x    = move_axis(box_x, dir_x, 11'(H_ACTIVE));
    assign next_y    = move_axis(box_y, dir_y, 11'(V_ACTIVE));

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            video_on_d <= 1'b0;
            hsync_d    <= 1'b1;
            vsync_d    <= 1'b1;
            hit_d      <= 1'b0;
            rgb        <= 12'h000;
            hsync_out  <= 1'b1;
            vsync_out  <= 1'b1;
            vsync_hist <= 1'b1;
        end else if (p_tick) begin
            video_on_d <= video_on;
            hsync_d    <= hsync_in;
            vsync_d    <= vsync_in;
            hit_d      <= hit;
            rgb        <= video_on_d ? (hit_d ? BOX_COLOR : BG_COLOR) : 12'h000;
            hsync_out  <= hsync_d;
            vsync_out  <= vsync_d;
            vsync_hist <= vsync_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_tick <= 1'b0;
            state_q    <= S_WAIT;
        end else begin
            frame_tick <= frame_det;
            state_q    <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_x    = 1'b0;
        ld_y    = 1'b0;
        case (state_q)
            S_WAIT:   if (frame_det) state_d = S_MOVE_X;
            S_MOVE_X: begin
                state_d = S_MOVE_Y;
                ld_x    = !pause;
            end
            S_MOVE_Y: begin
                state_d = S_WAIT;
                ld_y    = !pause;
            end
            default:  state_d = S_WAIT;
        endcase
    end

    // Position only moves in the MOVE states, i.e. during vertical blanking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            box_x <= 10'(INIT_X);
            box_y <= 10'(INIT_Y);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else begin
            if (ld_x) {box_x, dir_x} <= next_x;
            if (ld_y) {box_y, dir_y} <= next_y;
        end
    end

endmodule

// File: tb/tb_vga_box_renderer.sv
// Randomized bench for vga_box_renderer: three builds (default, right-edge start, small
// 40x40 area) checked against a frame-level model of box motion and pixel colour.
module tb_vga_box_renderer;

    localparam int N    = 3;
    localparam int BS   = 32;
    localparam int STEP = 2;

    int h_act [N] = '{640, 640, 40};
    int v_act [N] = '{480, 480, 40};
    int init_x[N] = '{100, 606, 1};
    int init_y[N] = '{60, 60, 1};

    logic       clk = 1'b0;
    logic       reset, p_tick, video_on, hsync_in, vsync_in, pause;
    logic [9:0] x, y;

    logic       hs_o[N], vs_o[N], ft_o[N];
    logic [11:0] rgb_o[N];
    logic [9:0] bx_o[N], by_o[N];

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        vga_box_renderer #(
            .H_ACTIVE(g == 2 ? 40 : 640),
            .V_ACTIVE(g == 2 ? 40 : 480),
            .INIT_X  (g == 0 ? 100 : (g == 1 ? 606 : 1)),
            .INIT_Y  (g == 2 ? 1 : 60)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .p_tick    (p_tick),
            .video_on  (video_on),
            .hsync_in  (hsync_in),
            .vsync_in  (vsync_in),
            .x         (x),
            .y         (y),
            .pause     (pause),
            .hsync_out (hs_o[g]),
            .vsync_out (vs_o[g]),
            .rgb       (rgb_o[g]),
            .frame_tick(ft_o[g])
        );
        assign bx_o[g] = u_dut.box_x;
        assign by_o[g] = u_dut.box_y;
    end

    // Reference model state
    int          m_x[N], m_y[N], m_dx[N], m_dy[N];
    logic [11:0] pend_rgb[N];
    logic        pend_hs, pend_vs, hist;
    int          cyc, last_acc;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clk_wait();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_x[k] = init_x[k];  m_y[k] = init_y[k];
            m_dx[k] = 1;         m_dy[k] = 1;
            pend_rgb[k] = 12'h000;
        end
        pend_hs  = 1'b1;
        pend_vs  = 1'b1;
        hist     = 1'b1;
        last_acc = -100;
    endtask

    task automatic bounce(input int p, input int d, input int lim, output int np, output int nd);
        np = p; nd = d;
        if (d > 0) begin
            if (p + STEP + BS > lim) begin np = lim - BS; nd = -1; end
            else np = p + STEP;
        end else begin
            if (p < STEP) begin np = 0; nd = 1; end
            else np = p - STEP;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_rgb%0d", tag, k), rgb_o[k], 12'h000);
            check($sformatf("%s_hs%0d", tag, k), hs_o[k], 1);
            check($sformatf("%s_vs%0d", tag, k), vs_o[k], 1);
            check($sformatf("%s_ft%0d", tag, k), ft_o[k], 0);
            check($sformatf("%s_bx%0d", tag, k), bx_o[k], init_x[k]);
            check($sformatf("%s_by%0d", tag, k), by_o[k], init_y[k]);
        end
    endtask

    // One pixel transaction on a p_tick, followed by gap-1 idle clocks with junk inputs.
    task automatic pix(input int px, input int py, input logic von, input logic hs,
                       input logic vs, input int gap);
        logic [11:0] new_rgb[N];
        logic        det, acc, hit;
        int          nx, ny, ndx, ndy;
        x = 10'(px); y = 10'(py);
        video_on = von; hsync_in = hs; vsync_in = vs; p_tick = 1'b1;
        for (int k = 0; k < N; k++) begin
            hit = (int'(x) >= m_x[k]) && (int'(x) < m_x[k] + BS) &&
                  (int'(y) >= m_y[k]) && (int'(y) < m_y[k] + BS);
            new_rgb[k] = von ? (hit ? 12'hF00 : 12'h00F) : 12'h000;
        end
        det  = hist && !vs;
        hist = vs;
        clk_wait();
        p_tick = 1'b0;
        acc = det && (cyc - last_acc >= 3);
        for (int k = 0; k < N; k++) begin
            check($sformatf("rgb%0d", k), rgb_o[k], pend_rgb[k]);
            check($sformatf("hsync%0d", k), hs_o[k], pend_hs);
            check($sformatf("vsync%0d", k), vs_o[k], pend_vs);
            check($sformatf("frame_tick%0d", k), ft_o[k], det);
            if (von) begin
                check($sformatf("active_bx%0d", k), bx_o[k], m_x[k]);
                check($sformatf("active_by%0d", k), by_o[k], m_y[k]);
            end
            pend_rgb[k] = new_rgb[k];
        end
        pend_hs = hs;
        pend_vs = vs;
        if (acc) begin
            last_acc = cyc;
            if (!pause) begin
                for (int k = 0; k < N; k++) begin
                    bounce(m_x[k], m_dx[k], h_act[k], nx, ndx);
                    bounce(m_y[k], m_dy[k], v_act[k], ny, ndy);
                    m_x[k] = nx; m_dx[k] = ndx;
                    m_y[k] = ny; m_dy[k] = ndy;
                end
            end
        end
        for (int i = 1; i < gap; i++) begin
            x = 10'($urandom); y = 10'($urandom);
            video_on = 1'($urandom); hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            clk_wait();
            for (int k = 0; k < N; k++) check($sformatf("frame_tick_idle%0d", k), ft_o[k], 0);
        end
    endtask

    // Compressed frame: box-edge probes for every build, random pixels, hblank, vblank.
    task automatic frame(input int nrand);
        int bx, by;
        for (int k = 0; k < N; k++) begin
            bx = m_x[k]; by = m_y[k];
            pix(bx, by, 1, 1, 1, 4);
            pix(bx + BS - 1, by + BS - 1, 1, 1, 1, 4);
            pix(bx - 1, by, 1, 1, 1, 4);
            pix(bx + BS, by, 1, 1, 1, 4);
            pix(bx, by - 1, 1, 1, 1, 4);
            pix(bx, by + BS, 1, 1, 1, 4);
        end
        for (int i = 0; i < nrand; i++)
            pix($urandom_range(0, 639), $urandom_range(0, 479), 1, 1, 1, 4);
        for (int i = 0; i < 3; i++) pix(700 + i, 100, 0, 0, 1, 4);
        for (int i = 0; i < 3; i++) pix(10, 490 + i, 0, 1'($urandom), 0, 4);
        for (int i = 0; i < 2; i++) pix(10, 500 + i, 0, 1, 1, 4);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        cyc = 0;
        reset = 1'b0; p_tick = 1'b0; video_on = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
        pause = 1'b0; x = '0; y = '0;
        model_reset();
        repeat (3) clk_wait();
        check_reset_outputs("in_reset");
        reset = 1'b1;
        clk_wait();

        // Specific pixels of the first frame, then normal bouncing frames.
        pix(100, 60, 1, 1, 1, 4);
        pix(132, 60, 1, 1, 1, 4);
        pix(650, 60, 0, 1, 1, 4);
        for (int f = 1; f <= 12; f++) begin
            frame(6);
            if (f == 1)  check("right_edge_f1", bx_o[1], 608);
            if (f == 3) begin
                check("box_x_f3", bx_o[0], 106);
                check("box_y_f3", by_o[0], 66);
                check("right_edge_f3", bx_o[1], 606);
            end
            if (f == 8)  check("left_edge_f8", bx_o[2], 0);
            if (f == 10) begin
                check("left_edge_f10", bx_o[2], 2);
                check("top_edge_f10", by_o[2], 2);
            end
        end

        // Paused frames still tick; position resumes afterwards.
        pause = 1'b1;
        frame(4);
        frame(4);
        pause = 1'b0;
        frame(4);

        // Back-to-back vsync falls while the FSM is busy: second one must not move the box.
        pix(0, 500, 0, 1, 1, 4);
        pix(0, 500, 0, 1, 0, 1);
        pix(0, 501, 0, 1, 1, 1);
        pix(0, 502, 0, 1, 0, 4);
        for (int i = 0; i < 3; i++) pix(0, 503 + i, 0, 1, 1, 4);
        frame(4);

        // Reset mid-line during the active region.
        for (int i = 0; i < 5; i++) pix($urandom_range(0, 639), 200, 1, 1, 1, 4);
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        clk_wait();
        clk_wait();
        reset = 1'b1;
        model_reset();
        frame(4);
        frame(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
